// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions used by the hazard unit and the forwarding unit.
package pipe_ctrl_pkg;

   localparam int unsigned REG_W = 4;

   typedef enum logic {
      RUN,
      WAIT
   } estado_t;

   // Forwarding mux selects, decoded by the EXE-stage forwarding unit
   localparam logic [1:0] FWD_ID  = 2'd0;
   localparam logic [1:0] FWD_MEM = 2'd1;
   localparam logic [1:0] FWD_WB  = 2'd2;

endpackage

// File: rtl/contador_saturado.sv
// Event counter that sticks at all-ones instead of wrapping.
module contador_saturado #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count_q <= '0;
      end else if (inc && (count_q != {W{1'b1}})) begin
         count_q <= count_q + W'(1);
      end
   end

   assign count = count_q;

endmodule

// File: rtl/unidad_deteccion_riesgos.sv
// Hazard detection: load-use stall, taken-branch flush and memory-wait freeze,
// with a wait-timeout monitor and saturating event counters.
module unidad_deteccion_riesgos
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned MAX_WAIT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] src1_ID,
   input  logic [REG_W-1:0] src2_ID,
   input  logic             use_src2_ID,
   input  logic [REG_W-1:0] st_src_ID,
   input  logic             use_st_ID,
   input  logic [REG_W-1:0] dest_EXE,
   input  logic             MEM_R_EN_EXE,
   input  logic             branch_taken_EXE,
   input  logic             mem_req_MEM,
   input  logic             mem_ready,
   input  logic             cnt_clr,
   output logic             stall_IF,
   output logic             stall_ID,
   output logic             bubble_EXE,
   output logic             flush_IF_ID,
   output logic             flush_ID_EXE,
   output logic             freeze,
   output logic             err_timeout,
   output logic [CNT_W-1:0] cnt_load_stall,
   output logic [CNT_W-1:0] cnt_freeze,
   output logic [CNT_W-1:0] cnt_flush
);

   localparam int unsigned WCW = $clog2(MAX_WAIT + 1);
   localparam logic [WCW-1:0] MAXW = WCW'(MAX_WAIT);

   estado_t        state_q, state_d;
   logic [WCW-1:0] wait_q, wait_d;
   logic           err_q, err_set;
   logic           freeze_w, load_use;

   assign freeze_w = mem_req_MEM && !mem_ready;

   // Register 0 is deliberately not exempt
   assign load_use = MEM_R_EN_EXE && ((src1_ID == dest_EXE)
                     || (use_src2_ID && (src2_ID == dest_EXE))
                     || (use_st_ID && (st_src_ID == dest_EXE)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         wait_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         if (cnt_clr) begin
            err_q <= 1'b0;
         end else if (err_set) begin
            err_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      unique case (state_q)
         RUN: begin
            if (freeze_w) begin
               state_d = WAIT;
               wait_d  = WCW'(1);
            end
         end
         WAIT: begin
            if (!freeze_w) begin
               state_d = RUN;
               wait_d  = '0;
            end else if (wait_q != MAXW) begin
               wait_d = wait_q + WCW'(1);
            end
         end
         default: begin
            state_d = RUN;
            wait_d  = '0;
         end
      endcase
      err_set = freeze_w && (wait_d == MAXW);
   end

   // Freeze outranks branch flush; a branch outranks load-use since it kills ID
   always_comb begin
      stall_IF     = 1'b0;
      stall_ID     = 1'b0;
      bubble_EXE   = 1'b0;
      flush_IF_ID  = 1'b0;
      flush_ID_EXE = 1'b0;
      if (!freeze_w) begin
         if (branch_taken_EXE) begin
            flush_IF_ID  = 1'b1;
            flush_ID_EXE = 1'b1;
         end else if (load_use) begin
            stall_IF   = 1'b1;
            stall_ID   = 1'b1;
            bubble_EXE = 1'b1;
         end
      end
   end

   assign freeze      = freeze_w;
   assign err_timeout = err_q;

   contador_saturado #(.W(CNT_W)) u_cnt_load_stall (
      .clk   (clk),
      .rst   (rst),
      .inc   (bubble_EXE),
      .clr   (cnt_clr),
      .count (cnt_load_stall)
   );

   contador_saturado #(.W(CNT_W)) u_cnt_freeze (
      .clk   (clk),
      .rst   (rst),
      .inc   (freeze_w),
      .clr   (cnt_clr),
      .count (cnt_freeze)
   );

   contador_saturado #(.W(CNT_W)) u_cnt_flush (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush_IF_ID),
      .clr   (cnt_clr),
      .count (cnt_flush)
   );

endmodule

// File: tb/tb_unidad_deteccion_riesgos.sv
// Directed bench for unidad_deteccion_riesgos with a scoreboard of expected values.
module tb_unidad_deteccion_riesgos;

   localparam int unsigned CNT_W    = 2;
   localparam int unsigned MAX_WAIT = 4;

   localparam logic [5:0] C_NONE   = 6'b000000;
   localparam logic [5:0] C_STALL  = 6'b111000;
   localparam logic [5:0] C_FLUSH  = 6'b000110;
   localparam logic [5:0] C_FREEZE = 6'b000001;

   logic clk = 1'b0;
   logic rst, use_src2_ID, use_st_ID, MEM_R_EN_EXE, branch_taken_EXE;
   logic mem_req_MEM, mem_ready, cnt_clr;
   logic [3:0] src1_ID, src2_ID, st_src_ID, dest_EXE;
   logic stall_IF, stall_ID, bubble_EXE, flush_IF_ID, flush_ID_EXE, freeze, err_timeout;
   logic [CNT_W-1:0] cnt_load_stall, cnt_freeze, cnt_flush;
   logic [5:0] ctrl;

   typedef struct {
      string       tag;
      logic [15:0] val;
   } exp_t;

   exp_t sb[$];
   int   tests  = 0;
   int   failed = 0;

   assign ctrl = {stall_IF, stall_ID, bubble_EXE, flush_IF_ID, flush_ID_EXE, freeze};

   always #5 clk = ~clk;

   unidad_deteccion_riesgos #(
      .CNT_W    (CNT_W),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .src1_ID          (src1_ID),
      .src2_ID          (src2_ID),
      .use_src2_ID      (use_src2_ID),
      .st_src_ID        (st_src_ID),
      .use_st_ID        (use_st_ID),
      .dest_EXE         (dest_EXE),
      .MEM_R_EN_EXE     (MEM_R_EN_EXE),
      .branch_taken_EXE (branch_taken_EXE),
      .mem_req_MEM      (mem_req_MEM),
      .mem_ready        (mem_ready),
      .cnt_clr          (cnt_clr),
      .stall_IF         (stall_IF),
      .stall_ID         (stall_ID),
      .bubble_EXE       (bubble_EXE),
      .flush_IF_ID      (flush_IF_ID),
      .flush_ID_EXE     (flush_ID_EXE),
      .freeze           (freeze),
      .err_timeout      (err_timeout),
      .cnt_load_stall   (cnt_load_stall),
      .cnt_freeze       (cnt_freeze),
      .cnt_flush        (cnt_flush)
   );

   task automatic idle();
      src1_ID = 4'd0; src2_ID = 4'd0; st_src_ID = 4'd0; dest_EXE = 4'd0;
      use_src2_ID = 1'b0; use_st_ID = 1'b0; MEM_R_EN_EXE = 1'b0;
      branch_taken_EXE = 1'b0; mem_req_MEM = 1'b0; mem_ready = 1'b0; cnt_clr = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input logic [15:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic pop_check(input logic [15:0] obs);
      exp_t e;
      tests++;
      if (sb.size() == 0) begin
         failed++;
         $display("FAIL sb_empty: got %0h required a queued entry", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            failed++;
            $error("FAIL %s: got %0h required %0h", e.tag, obs, e.val);
         end
      end
   endtask

   // Control outputs are combinational: settle, then compare
   task automatic chk_ctrl(input string tag, input logic [5:0] exp);
      push(tag, {10'd0, exp});
      #1;
      pop_check({10'd0, ctrl});
   endtask

   task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] exp_ls,
                          input logic [CNT_W-1:0] exp_fz, input logic [CNT_W-1:0] exp_fl,
                          input logic exp_err);
      push({tag, "_ls"}, 16'(exp_ls));
      push({tag, "_fz"}, 16'(exp_fz));
      push({tag, "_fl"}, 16'(exp_fl));
      push({tag, "_err"}, 16'(exp_err));
      pop_check(16'(cnt_load_stall));
      pop_check(16'(cnt_freeze));
      pop_check(16'(cnt_flush));
      pop_check(16'(err_timeout));
   endtask

   task automatic chk_err(input string tag, input logic exp);
      push(tag, 16'(exp));
      pop_check(16'(err_timeout));
   endtask

   task automatic clear_counters();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      chk_ctrl("reset_ctrl", C_NONE);
      tick();
      tick();
      rst = 1'b0;
      chk_cnt("reset", 2'd0, 2'd0, 2'd0, 1'b0);

      // Load-use on src1, then bubble drops MEM_R_EN_EXE
      MEM_R_EN_EXE = 1'b1; dest_EXE = 4'd5; src1_ID = 4'd5;
      chk_ctrl("lu_src1", C_STALL);
      tick();
      MEM_R_EN_EXE = 1'b0;
      chk_ctrl("lu_release", C_NONE);
      chk_cnt("lu", 2'd1, 2'd0, 2'd0, 1'b0);

      // Store-data source
      idle();
      MEM_R_EN_EXE = 1'b1; dest_EXE = 4'd3; use_st_ID = 1'b1; st_src_ID = 4'd3; src1_ID = 4'd1;
      chk_ctrl("lu_store", C_STALL);
      tick();

      // src2 only matters when used
      idle();
      MEM_R_EN_EXE = 1'b1; dest_EXE = 4'd3; src1_ID = 4'd1; src2_ID = 4'd3; st_src_ID = 4'd3;
      chk_ctrl("src2_unused", C_NONE);
      use_src2_ID = 1'b1;
      chk_ctrl("src2_used", C_STALL);
      tick();
      idle();
      chk_cnt("lu3", 2'd3, 2'd0, 2'd0, 1'b0);

      // Register 0 still compares
      MEM_R_EN_EXE = 1'b1;
      chk_ctrl("lu_r0", C_STALL);
      idle();
      clear_counters();
      chk_cnt("clr1", 2'd0, 2'd0, 2'd0, 1'b0);

      // Branch beats load-use
      MEM_R_EN_EXE = 1'b1; dest_EXE = 4'd5; src1_ID = 4'd5; branch_taken_EXE = 1'b1;
      chk_ctrl("br_lu", C_FLUSH);
      tick();
      idle();
      chk_cnt("br", 2'd0, 2'd0, 2'd1, 1'b0);

      // Memory wait with a pending branch: flush only once ready
      branch_taken_EXE = 1'b1; mem_req_MEM = 1'b1; mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk_ctrl("mw_freeze", C_FREEZE);
         tick();
      end
      mem_ready = 1'b1;
      chk_ctrl("mw_ready", C_FLUSH);
      tick();
      idle();
      chk_cnt("mw", 2'd0, 2'd3, 2'd2, 1'b0);
      clear_counters();

      // Timeout after MAX_WAIT unready cycles, sticky past release
      mem_req_MEM = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         chk_ctrl("to_freeze", C_FREEZE);
         tick();
         chk_err("to_err", (k >= MAX_WAIT));
      end
      mem_req_MEM = 1'b0;
      chk_ctrl("to_release", C_NONE);
      tick();
      chk_cnt("to", 2'd0, 2'd3, 2'd0, 1'b1);
      clear_counters();
      chk_cnt("to_clr", 2'd0, 2'd0, 2'd0, 1'b0);

      // Wait counter restarts after release: 3 cycles must not time out
      mem_req_MEM = 1'b1;
      for (int k = 0; k < 3; k++) tick();
      mem_req_MEM = 1'b0;
      tick();
      chk_err("short_wait", 1'b0);
      clear_counters();

      // Load-stall counter saturates
      for (int k = 0; k < 5; k++) begin
         MEM_R_EN_EXE = 1'b1; dest_EXE = 4'd7; src1_ID = 4'd7;
         tick();
         idle();
         tick();
      end
      chk_cnt("sat", 2'd3, 2'd0, 2'd0, 1'b0);

      // Reset mid-wait
      mem_req_MEM = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      chk_ctrl("rst_freeze", C_FREEZE);
      tick();
      rst = 1'b0;
      chk_cnt("rst_wait", 2'd0, 2'd0, 2'd0, 1'b0);
      for (int k = 1; k <= MAX_WAIT; k++) begin
         tick();
         chk_err("rst_to_err", (k >= MAX_WAIT));
      end
      idle();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
